jtag_reg_access: RTL and testbench

- Debug-module register-access engine between the JTAG DTM (DMI request/response) and the register file's debug port (`jtag_we_i`/`jtag_addr_i`/`jtag_data_i`/`jtag_data_o`).
- Implements a subset of the RISC-V debug-spec DM registers: data0, dmcontrol, dmstatus, abstractcs, command.
- Executes "access register" abstract commands against GPRs x0–x31.
- Also drives core halt request.

---
 rtl/jtag_reg_access_pkg.sv | 36 +++
 rtl/jtag_reg_access_dm_csr.sv | 59 +++++
 rtl/jtag_reg_access.sv | 113 +++++++++++
 tb/tb_jtag_reg_access.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_reg_access_pkg.sv
// jtag_reg_access_pkg: shared DM addresses, DMI codes, cmderr codes and command checks
package jtag_reg_access_pkg;
  localparam logic [6:0] A_DATA0 = 7'h04;
  localparam logic [6:0] A_DMCONTROL = 7'h10;
  localparam logic [6:0] A_DMSTATUS = 7'h11;
  localparam logic [6:0] A_ABSTRACTCS = 7'h16;
  localparam logic [6:0] A_COMMAND = 7'h17;
  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_READ = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;
  localparam logic [1:0] RESP_OK = 2'd0;
  localparam logic [1:0] RESP_FAIL = 2'd2;
  localparam logic [2:0] CMDERR_NONE = 3'd0;
  localparam logic [2:0] CMDERR_BUSY = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP = 3'd2;
  localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;
  localparam logic [15:0] REGNO_BASE = 16'h1000;
  localparam logic [2:0] AARSIZE_32 = 3'd2;
  localparam int DMC_HALTREQ = 31;
  localparam int DMC_NDMRESET = 1;
  localparam int DMC_DMACTIVE = 0;
  localparam int CMD_TRANSFER = 17;
  localparam int CMD_WRITE = 16;
  localparam int ACS_CMDERR_LSB = 8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

  // Classify an access-register command: unsupported shape first, then halt state
  function automatic logic [2:0] cmd_check(input logic [31:0] cmd, input logic halted, input int reg_num);
    logic [16:0] idx;
    idx = {1'b0, cmd[15:0]} - {1'b0, REGNO_BASE};
    return (cmd[31:24] != 8'h0 || cmd[22:20] != AARSIZE_32 || idx[16] || int'(idx) >= reg_num) ? CMDERR_NOTSUP :
           halted ? CMDERR_NONE : CMDERR_HALTRESUME;
  endfunction
endpackage

// File: rtl/jtag_reg_access_dm_csr.sv
// jtag_reg_access_dm_csr: debug-module register storage and DMI read mux
module jtag_reg_access_dm_csr
  import jtag_reg_access_pkg::*;
#(
  parameter int DMI_ADDR_W = 7,
  parameter int DM_VERSION = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DMI_ADDR_W-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic                  err_set,
  input  logic [2:0]            err_val,
  input  logic                  load,
  input  logic [31:0]           load_data,
  input  logic                  halted,
  input  logic                  busy,
  output logic [31:0]           rdata,
  output logic [31:0]           data0,
  output logic [2:0]            cmderr,
  output logic                  dmactive,
  output logic                  haltreq,
  output logic                  ndmreset
);
  localparam logic [DMI_ADDR_W-1:0] ADDR_DATA0 = DMI_ADDR_W'(A_DATA0);
  localparam logic [DMI_ADDR_W-1:0] ADDR_DMCONTROL = DMI_ADDR_W'(A_DMCONTROL);
  localparam logic [DMI_ADDR_W-1:0] ADDR_DMSTATUS = DMI_ADDR_W'(A_DMSTATUS);
  localparam logic [DMI_ADDR_W-1:0] ADDR_ABSTRACTCS = DMI_ADDR_W'(A_ABSTRACTCS);

  // Register updates; an abstract read result takes priority over a DMI data0 write
  always_ff @(posedge clk) begin
    if (!rst) begin
      data0 <= '0;
      cmderr <= CMDERR_NONE;
      dmactive <= 1'b0;
      haltreq <= 1'b0;
      ndmreset <= 1'b0;
    end else begin
      if (load) data0 <= load_data;
      else if (wr && addr == ADDR_DATA0 && dmactive) data0 <= wdata;
      if (wr && addr == ADDR_DMCONTROL) begin
        haltreq <= wdata[DMC_HALTREQ];
        ndmreset <= wdata[DMC_NDMRESET];
        dmactive <= wdata[DMC_DMACTIVE];
      end
      if (err_set) cmderr <= err_val;
      else if (wr && addr == ADDR_ABSTRACTCS) cmderr <= cmderr & ~wdata[ACS_CMDERR_LSB +: 3];
    end
  end

  // Read mux; command and unmapped addresses read as zero
  always_comb begin
    rdata = addr == ADDR_DATA0 ? data0 :
            addr == ADDR_DMCONTROL ? {haltreq, 29'b0, ndmreset, dmactive} :
            addr == ADDR_DMSTATUS ? {20'b0, !halted, !halted, halted, halted, 1'b1, 3'b0, 4'(DM_VERSION)} :
            addr == ADDR_ABSTRACTCS ? {19'b0, busy, 1'b0, cmderr, 4'b0, 4'd1} : '0;
  end
endmodule

// File: rtl/jtag_reg_access.sv
// jtag_reg_access: DMI-facing debug-module engine executing abstract GPR accesses
module jtag_reg_access
  import jtag_reg_access_pkg::*;
#(
  parameter int DMI_ADDR_W = 7,
  parameter int REG_NUM = 32,
  parameter int DM_VERSION = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dmi_req_valid_i,
  output logic                  dmi_req_ready_o,
  input  logic [1:0]            dmi_op_i,
  input  logic [DMI_ADDR_W-1:0] dmi_addr_i,
  input  logic [31:0]           dmi_data_i,
  output logic                  dmi_resp_valid_o,
  input  logic                  dmi_resp_ready_i,
  output logic [31:0]           dmi_resp_data_o,
  output logic [1:0]            dmi_resp_op_o,
  input  logic                  halted_i,
  output logic                  halt_req_o,
  output logic                  ndmreset_o,
  output logic                  reg_we_o,
  output logic [4:0]            reg_addr_o,
  output logic [31:0]           reg_wdata_o,
  input  logic [31:0]           reg_rdata_i
);
  localparam logic [DMI_ADDR_W-1:0] ADDR_COMMAND = DMI_ADDR_W'(A_COMMAND);

  state_t      state;
  logic        we_q;
  logic        accept;
  logic        wr;
  logic        cmd_ok;
  logic        err_set;
  logic        go_exec;
  logic        busy;
  logic        dmactive;
  logic [2:0]  chk;
  logic [2:0]  cmderr;
  logic [31:0] data0;
  logic [31:0] csr_rdata;
  logic [31:0] load_data;

  assign accept = dmi_req_valid_i && dmi_req_ready_o;
  assign wr = accept && dmi_op_i == OP_WRITE;
  assign chk = cmd_check(dmi_data_i, halted_i, REG_NUM);
  assign cmd_ok = wr && dmi_addr_i == ADDR_COMMAND && dmactive && cmderr == CMDERR_NONE;
  assign err_set = cmd_ok && chk != CMDERR_NONE;
  assign go_exec = cmd_ok && chk == CMDERR_NONE && dmi_data_i[CMD_TRANSFER];
  assign busy = state == S_EXEC;
  assign load_data = reg_addr_o == 5'd0 ? '0 : reg_rdata_i;
  assign reg_we_o = we_q && rst;

  jtag_reg_access_dm_csr #(.DMI_ADDR_W(DMI_ADDR_W), .DM_VERSION(DM_VERSION)) u_csr (
    .clk(clk),
    .rst(rst),
    .wr(wr),
    .addr(dmi_addr_i),
    .wdata(dmi_data_i),
    .err_set(err_set),
    .err_val(chk),
    .load(busy && !we_q),
    .load_data(load_data),
    .halted(halted_i),
    .busy(busy),
    .rdata(csr_rdata),
    .data0(data0),
    .cmderr(cmderr),
    .dmactive(dmactive),
    .haltreq(halt_req_o),
    .ndmreset(ndmreset_o)
  );

  // Request/response handshake and one-cycle abstract-command execution
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      dmi_req_ready_o <= 1'b1;
      dmi_resp_valid_o <= 1'b0;
      dmi_resp_data_o <= '0;
      dmi_resp_op_o <= RESP_OK;
      we_q <= 1'b0;
      reg_addr_o <= '0;
      reg_wdata_o <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          state <= go_exec ? S_EXEC : S_RESP;
          dmi_req_ready_o <= 1'b0;
          dmi_resp_valid_o <= !go_exec;
          dmi_resp_data_o <= dmi_op_i == OP_READ ? csr_rdata : '0;
          dmi_resp_op_o <= dmi_op_i == OP_RSVD ? RESP_FAIL : RESP_OK;
          if (go_exec) begin
            reg_addr_o <= dmi_data_i[4:0];
            reg_wdata_o <= data0;
            we_q <= dmi_data_i[CMD_WRITE];
          end
        end
        S_EXEC: begin
          state <= S_RESP;
          we_q <= 1'b0;
          dmi_resp_valid_o <= 1'b1;
        end
        default: if (dmi_resp_ready_i) begin
          state <= S_IDLE;
          dmi_resp_valid_o <= 1'b0;
          dmi_req_ready_o <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_reg_access.sv
// tb_jtag_reg_access: randomized DMI traffic checked against a register-level DM model
module tb_jtag_reg_access;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dmi_req_valid_i = 1'b0;
  logic        dmi_req_ready_o;
  logic [1:0]  dmi_op_i = 2'd0;
  logic [6:0]  dmi_addr_i = 7'd0;
  logic [31:0] dmi_data_i = 32'd0;
  logic        dmi_resp_valid_o;
  logic        dmi_resp_ready_i = 1'b0;
  logic [31:0] dmi_resp_data_o;
  logic [1:0]  dmi_resp_op_o;
  logic        halted_i = 1'b0;
  logic        halt_req_o;
  logic        ndmreset_o;
  logic        reg_we_o;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic [31:0] reg_rdata_i;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] regs [32];
  logic [31:0] m_regs [32];
  logic        fill = 1'b1;
  int          we_cnt = 0;
  logic [4:0]  we_addr = 5'd0;
  logic [31:0] we_data = 32'd0;

  logic [31:0] m_data0;
  logic        m_haltreq, m_ndmreset, m_dmactive;
  logic [2:0]  m_cmderr;

  jtag_reg_access dut (
    .clk(clk), .rst(rst),
    .dmi_req_valid_i(dmi_req_valid_i), .dmi_req_ready_o(dmi_req_ready_o),
    .dmi_op_i(dmi_op_i), .dmi_addr_i(dmi_addr_i), .dmi_data_i(dmi_data_i),
    .dmi_resp_valid_o(dmi_resp_valid_o), .dmi_resp_ready_i(dmi_resp_ready_i),
    .dmi_resp_data_o(dmi_resp_data_o), .dmi_resp_op_o(dmi_resp_op_o),
    .halted_i(halted_i), .halt_req_o(halt_req_o), .ndmreset_o(ndmreset_o),
    .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
    .reg_rdata_i(reg_rdata_i)
  );

  always #5 clk = ~clk;

  assign reg_rdata_i = reg_addr_o == 5'd0 ? 32'd0 : regs[reg_addr_o];

  // Register-file environment: x0 hardwired, records every write pulse
  always @(posedge clk) begin
    if (fill) for (int i = 0; i < 32; i++) regs[i] <= m_regs[i];
    else if (reg_we_o) begin
      if (reg_addr_o != 5'd0) regs[reg_addr_o] <= reg_wdata_o;
      we_cnt <= we_cnt + 1;
      we_addr <= reg_addr_o;
      we_data <= reg_wdata_o;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_data0 = 0;
    m_haltreq = 0;
    m_ndmreset = 0;
    m_dmactive = 0;
    m_cmderr = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [6:0] a);
    case (a)
      7'h04: return m_data0;
      7'h10: return (m_haltreq ? 32'h8000_0000 : 0) | (m_ndmreset ? 32'h2 : 0) | (m_dmactive ? 32'h1 : 0);
      7'h11: return 32'h2 | 32'h80 | (halted_i ? 32'h300 : 32'hC00);
      7'h16: return (32'(m_cmderr) << 8) | 32'h1;
      default: return 0;
    endcase
  endfunction

  task automatic model(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d,
                       output logic [31:0] er, output logic [1:0] eo, output logic ex,
                       output logic ew, output logic [4:0] wa, output logic [31:0] wd);
    int rn;
    er = 0; eo = 0; ex = 0; ew = 0; wa = 0; wd = 0;
    rn = int'(d[15:0]) - 4096;
    if (op == 2'd3) eo = 2'd2;
    else if (op == 2'd1) er = model_read(a);
    else if (op == 2'd2) begin
      if (a == 7'h04 && m_dmactive) m_data0 = d;
      if (a == 7'h10) begin
        m_haltreq = d[31];
        m_ndmreset = d[1];
        m_dmactive = d[0];
      end
      if (a == 7'h16) m_cmderr = m_cmderr & ~d[10:8];
      if (a == 7'h17 && m_dmactive && m_cmderr == 0) begin
        if (d[31:24] != 0 || d[22:20] != 3'd2 || rn < 0 || rn >= 32) m_cmderr = 3'd2;
        else if (!halted_i) m_cmderr = 3'd4;
        else if (d[17]) begin
          ex = 1;
          if (d[16]) begin
            ew = 1;
            wa = 5'(rn);
            wd = m_data0;
            if (rn != 0) m_regs[rn] = m_data0;
          end else m_data0 = rn == 0 ? 0 : m_regs[rn];
        end
      end
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctl"}, {25'b0, dmi_req_ready_o, dmi_resp_valid_o, dmi_resp_op_o, halt_req_o, ndmreset_o, reg_we_o}, 32'h40);
    check({tag, "_rdata"}, dmi_resp_data_o, 0);
    check({tag, "_raddr"}, 32'(reg_addr_o), 0);
    check({tag, "_wdata"}, reg_wdata_o, 0);
  endtask

  task automatic xact(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d, input int hold, input bit rst_in_resp);
    logic [31:0] er, wd;
    logic [1:0] eo;
    logic ex, ew;
    logic [4:0] wa;
    int c0, lat;
    model(op, a, d, er, eo, ex, ew, wa, wd);
    check("req_ready", 32'(dmi_req_ready_o), 1);
    c0 = we_cnt;
    dmi_req_valid_i = 1; dmi_op_i = op; dmi_addr_i = a; dmi_data_i = d;
    @(posedge clk); #1;
    dmi_req_valid_i = 0; dmi_op_i = 0; dmi_addr_i = 7'($urandom); dmi_data_i = $urandom;
    check("halt_req", 32'(halt_req_o), 32'(m_haltreq));
    check("ndmreset", 32'(ndmreset_o), 32'(m_ndmreset));
    lat = 1;
    while (!dmi_resp_valid_o && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, ex ? 2 : 1);
    check("resp_data", dmi_resp_data_o, er);
    check("resp_op", 32'(dmi_resp_op_o), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(dmi_resp_valid_o), 1);
      check("hold_data", dmi_resp_data_o, er);
      check("hold_ready", 32'(dmi_req_ready_o), 0);
    end
    if (rst_in_resp) begin
      rst = 0;
      @(posedge clk); #1;
      rst = 1;
      model_reset();
      check_reset_outs("resp_rst");
    end else begin
      dmi_resp_ready_i = 1;
      @(posedge clk); #1;
      dmi_resp_ready_i = 0;
    end
    check("we_pulses", we_cnt - c0, ew ? 1 : 0);
    if (ew) begin
      check("we_addr", 32'(we_addr), 32'(wa));
      check("we_data", we_data, wd);
    end
  endtask

  initial begin
    int c0, sel;
    logic [1:0] op;
    logic [6:0] a;
    logic [31:0] d;
    logic [6:0] amap [6];
    amap = '{7'h04, 7'h10, 7'h11, 7'h16, 7'h17, 7'h00};
    for (int i = 0; i < 32; i++) m_regs[i] = $urandom;
    m_regs[7] = 32'h1234_5678;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    fill = 0;
    check_reset_outs("reset");
    rst = 1;

    xact(2'd2, 7'h10, 32'h8000_0001, 0, 0);
    xact(2'd1, 7'h10, 0, 0, 0);
    halted_i = 1;
    xact(2'd2, 7'h04, 32'hDEAD_BEEF, 0, 0);
    xact(2'd2, 7'h17, 32'h0023_1005, 0, 0);
    xact(2'd2, 7'h17, 32'h0022_1007, 0, 0);
    xact(2'd1, 7'h04, 0, 0, 0);
    xact(2'd2, 7'h17, 32'h0023_0020, 0, 0);
    xact(2'd2, 7'h17, 32'h0023_1005, 0, 0);
    xact(2'd1, 7'h16, 0, 0, 0);
    xact(2'd2, 7'h16, 32'h0000_0700, 0, 0);
    xact(2'd2, 7'h17, 32'h0023_1005, 0, 0);
    xact(2'd2, 7'h17, 32'h0020_1000, 0, 0);
    halted_i = 0;
    xact(2'd2, 7'h17, 32'h0023_1003, 0, 0);
    xact(2'd1, 7'h16, 0, 0, 0);
    xact(2'd2, 7'h16, 32'h0000_0700, 0, 0);
    xact(2'd3, 7'h04, 32'h5555_5555, 0, 0);
    xact(2'd0, 7'h04, 0, 0, 0);
    xact(2'd1, 7'h11, 0, 0, 0);
    halted_i = 1;
    xact(2'd1, 7'h11, 0, 5, 1);
    xact(2'd2, 7'h04, 32'h1111_1111, 0, 0);
    xact(2'd2, 7'h17, 32'h0023_1004, 0, 0);
    xact(2'd1, 7'h04, 0, 0, 0);

    xact(2'd2, 7'h10, 32'h1, 0, 0);
    xact(2'd2, 7'h04, 32'hCAFE_F00D, 0, 0);
    c0 = we_cnt;
    dmi_req_valid_i = 1; dmi_op_i = 2'd2; dmi_addr_i = 7'h17; dmi_data_i = 32'h0023_1009;
    @(posedge clk); #1;
    dmi_req_valid_i = 0;
    check("exec_we", 32'(reg_we_o), 1);
    rst = 0;
    #1;
    check("rst_we", 32'(reg_we_o), 0);
    @(posedge clk); #1;
    rst = 1;
    model_reset();
    check_reset_outs("exec_rst");
    check("exec_rst_pulses", we_cnt - c0, 0);

    xact(2'd2, 7'h10, 32'h1, 0, 0);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) halted_i = ~halted_i;
      sel = $urandom_range(0, 9);
      op = sel == 0 ? 2'd0 : sel == 1 ? 2'd3 : sel < 6 ? 2'd1 : 2'd2;
      a = amap[$urandom_range(0, 5)];
      if (a == 7'h00) a = 7'($urandom);
      d = $urandom;
      if (a == 7'h10) d[0] = $urandom_range(0, 9) != 0;
      if (a == 7'h16 && $urandom_range(0, 1) == 1) d = 32'h700;
      if (a == 7'h17) begin
        d = {($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h0, 1'b0,
             ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd2, 2'b0,
             $urandom_range(0, 5) != 0, 1'($urandom),
             ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 16'h1100)) : 16'h1000 + 16'($urandom_range(0, 31))};
      end
      xact(op, a, d, $urandom_range(0, 2), 0);
    end
    xact(2'd1, 7'h04, 0, 0, 0);
    xact(2'd1, 7'h16, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
